// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: PC -> imem req/ack -> IF/ID valid pulse.
// Optional last-fetch hit buffer enabled by IF_LASTHIT_EN.
module if_fetch_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               stall_o,
  input  logic               hold_i,
  input  logic               flush_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               instr_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    ipc_q, ipc_d;
  logic                 vld_q, vld_d;
  logic [INSTR_W-1:0]   buf_data_q, buf_data_d;
  logic [ADDR_W-1:0]    buf_pc_q, buf_pc_d;

  logic                 req;
  logic                 dlv;
  logic                 rel;
  logic                 cap;
  logic                 hit;
  logic [INSTR_W-1:0]   hit_data;
  logic [INSTR_W-1:0]   dlv_data;
  logic [ADDR_W-1:0]    dlv_pc;

`ifdef IF_LASTHIT_EN
  logic [ADDR_W-1:0]    lh_tag_q;
  logic [INSTR_W-1:0]   lh_data_q;
  logic                 lh_vld_q;

  assign hit = (state_q == S_REQ) & start_i
             & lh_vld_q & (lh_tag_q == pc_i);
  assign hit_data = lh_data_q;

  // Cleared while stopped so a restart never hits stale code.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lh_tag_q  <= '0;
      lh_data_q <= '0;
      lh_vld_q  <= 1'b0;
    end else if (!start_i) begin
      lh_vld_q  <= 1'b0;
    end else if (mem_req_o & mem_ack_i) begin
      lh_tag_q  <= pc_i;
      lh_data_q <= mem_data_i;
      lh_vld_q  <= 1'b1;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    req      = 1'b0;
    dlv      = 1'b0;
    rel      = 1'b0;
    cap      = 1'b0;
    dlv_data = mem_data_i;
    dlv_pc   = pc_i;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_REQ;
      end
      S_REQ: begin
        req = ~hit;
        if (hit) dlv_data = hit_data;
        if (!start_i) begin
          state_d = mem_ack_i ? S_IDLE : S_DRAIN;
        end else if (mem_ack_i | hit) begin
          if (hold_i) begin
            cap     = 1'b1;
            state_d = S_HOLD;
          end else begin
            dlv = 1'b1;
          end
        end
      end
      S_HOLD: begin
        dlv_data = buf_data_q;
        dlv_pc   = buf_pc_q;
        if (!start_i) begin
          state_d = S_IDLE;
        end else if (!hold_i) begin
          dlv     = 1'b1;
          state_d = S_REQ;
        end else if (flush_i) begin
          rel     = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        req = 1'b1;
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    ipc_d      = ipc_q;
    vld_d      = dlv & ~flush_i;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    if (dlv) begin
      instr_d = dlv_data;
      ipc_d   = dlv_pc;
    end
    if (cap) begin
      buf_data_d = dlv_data;
      buf_pc_d   = pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ipc_q      <= '0;
      vld_q      <= 1'b0;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      ipc_q      <= ipc_d;
      vld_q      <= vld_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  assign mem_req_o     = req;
  assign mem_addr_o    = pc_i;
  assign stall_o       = start_i & ~(dlv | rel);
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = vld_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: cycle table, reset/last-hit sequences,
// and a randomized memory-latency stream checked by a scoreboard.
module tb_if_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        stall_o;
  logic        hold_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;

  if_fetch_ctrl #(.ADDR_W(32), .INSTR_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .stall_o      (stall_o),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a * 32'h0001_0003;
  endfunction

  typedef struct {
    logic [3:0]  in;   // start, hold, flush, ack
    logic [31:0] pc;
    logic [2:0]  ex;   // req, stall, valid
    logic [31:0] ipc;
  } vec_t;

  function automatic vec_t row(input logic [3:0] in, input logic [31:0] pc,
                               input logic [2:0] ex, input logic [31:0] ipc);
    vec_t v;
    v.in = in; v.pc = pc; v.ex = ex; v.ipc = ipc;
    return v;
  endfunction

  vec_t tbl[23];

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t q[$];

  initial begin
    exp_t e;
    exp_t hb;
    logic [31:0] pc_m;
    logic holding, stall_s, ack, pushed;
    int wt, lat;

    tbl[0]  = row(4'b1000, 32'h00, 3'b010, 32'h00);
    tbl[1]  = row(4'b1000, 32'h00, 3'b110, 32'h00);
    tbl[2]  = row(4'b1000, 32'h00, 3'b110, 32'h00);
    tbl[3]  = row(4'b1001, 32'h00, 3'b100, 32'h00);
    tbl[4]  = row(4'b1001, 32'h04, 3'b101, 32'h00);
    tbl[5]  = row(4'b1001, 32'h08, 3'b101, 32'h04);
    tbl[6]  = row(4'b1001, 32'h0C, 3'b101, 32'h08);
    tbl[7]  = row(4'b1101, 32'h10, 3'b111, 32'h0C);
    tbl[8]  = row(4'b1100, 32'h10, 3'b010, 32'h0C);
    tbl[9]  = row(4'b1100, 32'h10, 3'b010, 32'h0C);
    tbl[10] = row(4'b1000, 32'h10, 3'b000, 32'h0C);
    tbl[11] = row(4'b1000, 32'h20, 3'b111, 32'h10);
    tbl[12] = row(4'b1011, 32'h20, 3'b100, 32'h10);
    tbl[13] = row(4'b1101, 32'h24, 3'b110, 32'h20);
    tbl[14] = row(4'b1110, 32'h24, 3'b000, 32'h20);
    tbl[15] = row(4'b1001, 32'h28, 3'b100, 32'h20);
    tbl[16] = row(4'b0000, 32'h2C, 3'b101, 32'h28);
    tbl[17] = row(4'b0000, 32'h2C, 3'b100, 32'h28);
    tbl[18] = row(4'b0001, 32'h2C, 3'b100, 32'h28);
    tbl[19] = row(4'b0000, 32'h2C, 3'b000, 32'h28);
    tbl[20] = row(4'b1000, 32'h30, 3'b010, 32'h28);
    tbl[21] = row(4'b0001, 32'h30, 3'b100, 32'h28);
    tbl[22] = row(4'b0000, 32'h30, 3'b000, 32'h28);

    rst_i = 1'b0; start_i = 1'b0; pc_i = '0; hold_i = 1'b0;
    flush_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    #1;
    chk("rst_req", {31'b0, mem_req_o}, 0);
    chk("rst_valid", {31'b0, instr_valid_o}, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_ipc", instr_pc_o, 0);
    chk("rst_stall_lo", {31'b0, stall_o}, 0);
    start_i = 1'b1;
    #1 chk("rst_stall_hi", {31'b0, stall_o}, 1);
    #5 rst_i = 1'b1;
    #1;

    for (int i = 0; i < 23; i++) begin
      {start_i, hold_i, flush_i, mem_ack_i} = tbl[i].in;
      pc_i = tbl[i].pc;
      mem_data_i = dat(pc_i);
      @(negedge clk_i);
      chk($sformatf("t%0d_req", i), {31'b0, mem_req_o}, {31'b0, tbl[i].ex[2]});
      chk($sformatf("t%0d_stall", i), {31'b0, stall_o}, {31'b0, tbl[i].ex[1]});
      chk($sformatf("t%0d_valid", i), {31'b0, instr_valid_o},
          {31'b0, tbl[i].ex[0]});
      chk($sformatf("t%0d_ipc", i), instr_pc_o, tbl[i].ipc);
      chk($sformatf("t%0d_instr", i), instr_o, dat(tbl[i].ipc));
      if (tbl[i].ex[2]) chk($sformatf("t%0d_addr", i), mem_addr_o, tbl[i].pc);
      @(posedge clk_i);
      #1;
    end

    // Reset in the middle of an outstanding request.
    start_i = 1'b1; pc_i = 32'h50; mem_ack_i = 1'b0; hold_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("mid_req", {31'b0, mem_req_o}, 1);
    #1 rst_i = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, mem_req_o}, 0);
    chk("mid_rst_valid", {31'b0, instr_valid_o}, 0);
    chk("mid_rst_instr", instr_o, 0);
    chk("mid_rst_ipc", instr_pc_o, 0);
    chk("mid_rst_stall", {31'b0, stall_o}, 1);
    start_i = 1'b0;
    #1 rst_i = 1'b1;

`ifdef IF_LASTHIT_EN
    @(posedge clk_i); #1;
    start_i = 1'b1; pc_i = 32'h40; mem_data_i = dat(32'h40);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b1;
    @(negedge clk_i);
    chk("lh_first_req", {31'b0, mem_req_o}, 1);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0; mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    chk("lh_hit_req", {31'b0, mem_req_o}, 0);
    chk("lh_hit_stall", {31'b0, stall_o}, 0);
    chk("lh_first_valid", {31'b0, instr_valid_o}, 1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("lh_hit_valid", {31'b0, instr_valid_o}, 1);
    chk("lh_hit_ipc", instr_pc_o, 32'h40);
    chk("lh_hit_instr", instr_o, dat(32'h40));
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
`endif

    // Random-latency stream with random downstream hold.
    pc_m = 32'h100; holding = 1'b0; stall_s = 1'b1;
    wt = 0; lat = $urandom_range(0, 2);
    mem_ack_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk_i);
      if (!stall_s) pc_m += 32'h4;
      #1;
      pc_i = pc_m;
      mem_data_i = dat(pc_m);
      hold_i = (n < 295) && ($urandom_range(0, 3) == 0);
      #1;
      ack = mem_req_o && (wt >= lat) && (n < 295);
      mem_ack_i = ack;
      if (ack) begin
        wt = 0;
        lat = $urandom_range(0, 2);
      end else if (mem_req_o) begin
        wt++;
      end
      @(negedge clk_i);
      if (instr_valid_o) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_spurious: got valid pc %h want no valid",
                   instr_pc_o);
        end else begin
          e = q.pop_front();
          chk("sb_pc", instr_pc_o, e.pc);
          chk("sb_instr", instr_o, e.ins);
        end
      end
      pushed = 1'b0;
      if (holding && !hold_i) begin
        q.push_back(hb);
        holding = 1'b0;
        pushed = 1'b1;
      end else if (ack) begin
        e.pc = pc_m;
        e.ins = dat(pc_m);
        if (hold_i) begin
          hb = e;
          holding = 1'b1;
        end else begin
          q.push_back(e);
          pushed = 1'b1;
        end
      end
      chk("sb_stall", {31'b0, stall_o}, {31'b0, ~pushed});
      stall_s = stall_o;
    end
    chk("sb_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
